// File: rtl/fsm_encaixotamento_if.sv
// Boxing-station bus: operator/conveyor inputs and station status outputs.
interface fsm_encaixotamento_if;
   logic       garrafa_entregue;
   logic       sw_adicionar_caixa;
   logic       zera_contagem;
   logic       pronto_receber;
   logic       fechando_caixa;
   logic       incrementar_duzia;
   logic       garrafa_perdida;
   logic       alarme_sem_caixa;
   logic [3:0] garrafas_na_caixa;
   logic [6:0] estoque_caixas;

   modport master (
      output garrafa_entregue, sw_adicionar_caixa, zera_contagem,
      input  pronto_receber, fechando_caixa, incrementar_duzia, garrafa_perdida,
             alarme_sem_caixa, garrafas_na_caixa, estoque_caixas
   );

   modport slave (
      input  garrafa_entregue, sw_adicionar_caixa, zera_contagem,
      output pronto_receber, fechando_caixa, incrementar_duzia, garrafa_perdida,
             alarme_sem_caixa, garrafas_na_caixa, estoque_caixas
   );
endinterface

// File: rtl/fsm_encaixotamento.sv
// Boxing station: fills boxes with 12 bottles, seals them and tracks empty-box stock.
// All outputs registered except alarme_sem_caixa, decoded from the stock register.
module fsm_encaixotamento #(
   parameter int TEMPO_FECHAMENTO = 8,
   parameter int ESTOQUE_INICIAL  = 5,
   parameter int ESTOQUE_MAX      = 99
) (
   input  logic                  clk,
   input  logic                  reset,
   fsm_encaixotamento_if.slave   bus
);
   typedef enum logic [1:0] {SEM_CAIXA, POSICIONAR, ENCHENDO, FECHANDO} estado_t;

   localparam int            TW        = (TEMPO_FECHAMENTO > 1) ? $clog2(TEMPO_FECHAMENTO) : 1;
   localparam logic [TW-1:0] TIMER_INI = TW'(TEMPO_FECHAMENTO - 1);
   localparam logic [6:0]    EST_MAX   = 7'(ESTOQUE_MAX);
   localparam logic [6:0]    EST_INI   = 7'(ESTOQUE_INICIAL);

   estado_t       estado_q;
   logic [TW-1:0] timer_q;
   logic          sw_q;
   logic          pronto_q;
   logic          fech_q;
   logic          duzia_q;
   logic          perdida_q;
   logic [3:0]    garrafas_q;
   logic [6:0]    estoque_q;
   logic [6:0]    estoque_d;
   logic          add_edge;

   assign add_edge = bus.sw_adicionar_caixa & ~sw_q;

   // An add and a positioning decrement in the same cycle cancel out.
   always_comb begin
      estoque_d = estoque_q;
      if (add_edge && estado_q != POSICIONAR) begin
         if (estoque_q < EST_MAX) estoque_d = estoque_q + 7'd1;
      end else if (!add_edge && estado_q == POSICIONAR && estoque_q != 7'd0) begin
         estoque_d = estoque_q - 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q   <= SEM_CAIXA;
         timer_q    <= '0;
         sw_q       <= bus.sw_adicionar_caixa;
         pronto_q   <= 1'b0;
         fech_q     <= 1'b0;
         duzia_q    <= 1'b0;
         perdida_q  <= 1'b0;
         garrafas_q <= 4'd0;
         estoque_q  <= EST_INI;
      end else begin
         sw_q      <= bus.sw_adicionar_caixa;
         estoque_q <= estoque_d;
         perdida_q <= bus.garrafa_entregue & ~pronto_q;
         duzia_q   <= 1'b0;
         case (estado_q)
            SEM_CAIXA: begin
               if (estoque_q != 7'd0) estado_q <= POSICIONAR;
            end
            POSICIONAR: begin
               garrafas_q <= 4'd0;
               pronto_q   <= 1'b1;
               estado_q   <= ENCHENDO;
            end
            ENCHENDO: begin
               if (bus.zera_contagem) begin
                  garrafas_q <= 4'd0;
               end else if (bus.garrafa_entregue) begin
                  if (garrafas_q == 4'd11) begin
                     garrafas_q <= 4'd12;
                     pronto_q   <= 1'b0;
                     fech_q     <= 1'b1;
                     timer_q    <= TIMER_INI;
                     duzia_q    <= (TEMPO_FECHAMENTO == 1);
                     estado_q   <= FECHANDO;
                  end else begin
                     garrafas_q <= garrafas_q + 4'd1;
                  end
               end
            end
            FECHANDO: begin
               // The dozen pulse is raised so it lines up with the last sealing cycle.
               if (timer_q == '0) begin
                  fech_q   <= 1'b0;
                  estado_q <= (estoque_q != 7'd0) ? POSICIONAR : SEM_CAIXA;
               end else begin
                  timer_q <= timer_q - TW'(1);
                  duzia_q <= (timer_q == TW'(1));
               end
            end
            default: estado_q <= SEM_CAIXA;
         endcase
      end
   end

   assign bus.pronto_receber    = pronto_q;
   assign bus.fechando_caixa    = fech_q;
   assign bus.incrementar_duzia = duzia_q;
   assign bus.garrafa_perdida   = perdida_q;
   assign bus.garrafas_na_caixa = garrafas_q;
   assign bus.estoque_caixas    = estoque_q;
   assign bus.alarme_sem_caixa  = (estoque_q == 7'd0);
endmodule

// File: tb/tb_fsm_encaixotamento.sv
// Self-checking bench for fsm_encaixotamento: direct checks plus event scoreboards.
module tb_fsm_encaixotamento;
   localparam int TEMPO = 8;

   logic clk = 1'b0;
   logic reset;
   fsm_encaixotamento_if bus ();

   fsm_encaixotamento #(
      .TEMPO_FECHAMENTO(TEMPO),
      .ESTOQUE_INICIAL (5),
      .ESTOQUE_MAX     (99)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_seal[$];
   int exp_duzia[$];
   int exp_lost[$];
   int run = 0;
   int duzia_total = 0;
   int m_count = 0;
   int m_stock = 0;
   int m_seals = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bottle();
      bus.garrafa_entregue = 1'b1;
      tick();
      bus.garrafa_entregue = 1'b0;
   endtask

   task automatic fill_rest();
      while (m_count < 12) begin
         if (m_count == 11) begin
            exp_seal.push_back(TEMPO);
            exp_duzia.push_back(12);
            m_seals++;
         end
         send_bottle();
         m_count++;
         chk("count_fill", bus.garrafas_na_caixa, m_count);
      end
      chk("seal_fech", bus.fechando_caixa, 1);
      chk("seal_pronto", bus.pronto_receber, 0);
   endtask

   task automatic wait_pronto(input int bound);
      int n = 0;
      while (!bus.pronto_receber && n < bound) begin
         tick();
         n++;
      end
      chk("pronto_timeout", bus.pronto_receber, 1);
   endtask

   task automatic wait_fech_low(input int bound);
      int n = 0;
      while (bus.fechando_caixa && n < bound) begin
         tick();
         n++;
      end
      chk("fech_timeout", bus.fechando_caixa, 0);
   endtask

   // Output monitor: pops expectations when the DUT emits events.
   always @(negedge clk) begin
      if (reset) begin
         run = 0;
      end else begin
         if (bus.fechando_caixa) begin
            run++;
         end else if (run != 0) begin
            if (exp_seal.size() == 0) chk("seal_unexpected", run, 0);
            else chk("seal_len", run, exp_seal.pop_front());
            run = 0;
         end
         if (bus.incrementar_duzia) begin
            duzia_total++;
            chk("duzia_with_fech", bus.fechando_caixa, 1);
            if (exp_duzia.size() == 0) chk("duzia_unexpected", 1, 0);
            else chk("duzia_count", bus.garrafas_na_caixa, exp_duzia.pop_front());
         end
         if (bus.garrafa_perdida) begin
            if (exp_lost.size() == 0) chk("lost_unexpected", 1, 0);
            else chk("lost_count", bus.garrafas_na_caixa, exp_lost.pop_front());
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int d0;
      reset = 1'b1;
      bus.garrafa_entregue   = 1'b0;
      bus.sw_adicionar_caixa = 1'b0;
      bus.zera_contagem      = 1'b0;
      tick();
      tick();
      chk("rst_stock", bus.estoque_caixas, 5);
      chk("rst_count", bus.garrafas_na_caixa, 0);
      chk("rst_pronto", bus.pronto_receber, 0);
      chk("rst_fech", bus.fechando_caixa, 0);
      chk("rst_duzia", bus.incrementar_duzia, 0);
      chk("rst_perdida", bus.garrafa_perdida, 0);
      chk("rst_alarme", bus.alarme_sem_caixa, 0);

      reset = 1'b0;
      tick();
      chk("pos_pronto", bus.pronto_receber, 0);
      chk("pos_stock", bus.estoque_caixas, 5);
      tick();
      m_stock = 4;
      chk("ench_pronto", bus.pronto_receber, 1);
      chk("ench_stock", bus.estoque_caixas, m_stock);
      chk("ench_count", bus.garrafas_na_caixa, 0);

      // Box 1, with a bottle arriving during sealing.
      fill_rest();
      tick();
      exp_lost.push_back(12);
      send_bottle();
      chk("fech_count_hold", bus.garrafas_na_caixa, 12);
      wait_pronto(40);
      m_stock--;
      m_count = 0;
      chk("box1_stock", bus.estoque_caixas, m_stock);
      chk("box1_count", bus.garrafas_na_caixa, 0);
      chk("box1_duzias", duzia_total, 1);

      // Box 2: count clear, and clear winning over a simultaneous bottle.
      repeat (3) begin
         send_bottle();
         m_count++;
         chk("count_pre_zera", bus.garrafas_na_caixa, m_count);
      end
      bus.zera_contagem = 1'b1;
      tick();
      bus.zera_contagem = 1'b0;
      m_count = 0;
      chk("zera_count", bus.garrafas_na_caixa, m_count);
      chk("zera_pronto", bus.pronto_receber, 1);
      send_bottle();
      send_bottle();
      m_count = 2;
      bus.zera_contagem    = 1'b1;
      bus.garrafa_entregue = 1'b1;
      tick();
      bus.zera_contagem    = 1'b0;
      bus.garrafa_entregue = 1'b0;
      m_count = 0;
      chk("zera_wins", bus.garrafas_na_caixa, m_count);
      fill_rest();
      wait_pronto(40);
      m_stock--;
      m_count = 0;
      chk("box2_stock", bus.estoque_caixas, m_stock);

      // Drain remaining stock.
      repeat (2) begin
         fill_rest();
         wait_pronto(40);
         m_stock--;
         m_count = 0;
         chk("drain_stock", bus.estoque_caixas, m_stock);
      end
      chk("alarm_in_ench", bus.alarme_sem_caixa, 1);
      fill_rest();
      wait_fech_low(20);
      chk("sem_alarme", bus.alarme_sem_caixa, 1);
      chk("sem_pronto", bus.pronto_receber, 0);
      chk("sem_stock", bus.estoque_caixas, 0);
      repeat (3) tick();
      chk("sem_stays", bus.pronto_receber, 0);
      exp_lost.push_back(12);
      send_bottle();

      // One switch edge restocks and restarts the cycle.
      bus.sw_adicionar_caixa = 1'b1;
      tick();
      chk("add_stock", bus.estoque_caixas, 1);
      chk("add_alarme", bus.alarme_sem_caixa, 0);
      tick();
      chk("restart_pos", bus.pronto_receber, 0);
      tick();
      chk("restart_pronto", bus.pronto_receber, 1);
      chk("restart_stock", bus.estoque_caixas, 0);
      chk("restart_count", bus.garrafas_na_caixa, 0);
      bus.sw_adicionar_caixa = 1'b0;
      tick();

      // Saturation at the stock limit.
      repeat (98) begin
         bus.sw_adicionar_caixa = 1'b1;
         tick();
         bus.sw_adicionar_caixa = 1'b0;
         tick();
      end
      chk("stock_98", bus.estoque_caixas, 98);
      bus.sw_adicionar_caixa = 1'b1;
      repeat (50) tick();
      chk("stock_99_held", bus.estoque_caixas, 99);
      bus.sw_adicionar_caixa = 1'b0;
      tick();
      bus.sw_adicionar_caixa = 1'b1;
      tick();
      chk("stock_sat", bus.estoque_caixas, 99);
      bus.sw_adicionar_caixa = 1'b0;
      tick();

      // Reset on the third sealing cycle, switch held high through reset.
      m_count = 0;
      fill_rest();
      tick();
      tick();
      bus.sw_adicionar_caixa = 1'b1;
      reset = 1'b1;
      tick();
      exp_seal.delete();
      exp_duzia.delete();
      m_seals--;
      chk("abort_fech", bus.fechando_caixa, 0);
      chk("abort_duzia", bus.incrementar_duzia, 0);
      chk("abort_stock", bus.estoque_caixas, 5);
      chk("abort_count", bus.garrafas_na_caixa, 0);
      tick();
      d0 = duzia_total;
      reset = 1'b0;
      tick();
      tick();
      chk("sw_no_add", bus.estoque_caixas, 4);
      chk("abort_restart", bus.pronto_receber, 1);
      repeat (12) tick();
      chk("abort_no_duzia", duzia_total, d0);
      bus.sw_adicionar_caixa = 1'b0;
      tick();

      chk("seals_total", duzia_total, m_seals);
      chk("seal_q_empty", exp_seal.size(), 0);
      chk("lost_q_empty", exp_lost.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fsm_encaixotamento.md
FSM_ENCAIXOTAMENTO -- requirements
Module: fsm_encaixotamento

Interface
REQ-001 Parameter TEMPO_FECHAMENTO, default 8, clock cycles the box-sealing actuator stays on.
REQ-002 Parameter ESTOQUE_INICIAL, default 5, empty-box stock loaded at reset.
REQ-003 Parameter ESTOQUE_MAX, default 99, stock saturation limit; must fit in 7 bits.
REQ-004 clk  input  1  system clock; one clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 garrafa_entregue  input  1  one-cycle pulse: an approved bottle has reached the boxing position.
REQ-007 sw_adicionar_caixa  input  1  level switch; each rising edge adds one empty box to stock.
REQ-008 zera_contagem  input  1  one-cycle pulse; clears the bottles-in-box count only.
REQ-009 pronto_receber  output  1  high when a box is in position and can accept a bottle.
REQ-010 fechando_caixa  output  1  sealing actuator drive (LED).
REQ-011 incrementar_duzia  output  1  one-cycle pulse per sealed box of 12 bottles.
REQ-012 garrafa_perdida  output  1  one-cycle pulse: garrafa_entregue arrived while pronto_receber was low.
REQ-013 alarme_sem_caixa  output  1  high whenever stock is 0.
REQ-014 garrafas_na_caixa  output  4  bottles in current box, 0..12.
REQ-015 estoque_caixas  output  7  empty boxes in stock, 0..ESTOQUE_MAX.

Function
REQ-016 States: SEM_CAIXA, POSICIONAR, ENCHENDO, FECHANDO; all outputs registered.
REQ-017 SEM_CAIXA: pronto_receber=0; move to POSICIONAR on the first cycle stock is nonzero.
REQ-018 POSICIONAR lasts exactly 1 cycle: decrement stock by 1, clear garrafas_na_caixa to 0, go to ENCHENDO.
REQ-019 ENCHENDO: pronto_receber=1; each garrafa_entregue increments garrafas_na_caixa by 1.
REQ-020 The pulse that brings the count to 12 moves the FSM to FECHANDO on the next edge; pronto_receber drops in that same edge.
REQ-021 FECHANDO: fechando_caixa=1 for exactly TEMPO_FECHAMENTO cycles; pronto_receber=0; count holds at 12.
REQ-022 On the last FECHANDO cycle, incrementar_duzia pulses once; next state is POSICIONAR if stock>0, else SEM_CAIXA.
REQ-023 garrafa_entregue while pronto_receber=0 does not change the count and pulses garrafa_perdida on the next cycle.
REQ-024 sw_adicionar_caixa edge detection uses a registered copy; one increment per 0->1 transition regardless of hold time.
REQ-025 Stock saturates at ESTOQUE_MAX; an add at the limit is ignored.
REQ-026 Add-edge and POSICIONAR decrement in the same cycle: net stock unchanged.
REQ-027 alarme_sem_caixa is combinationally equal to (estoque_caixas==0) on the registered value.
REQ-028 zera_contagem in ENCHENDO clears the count to 0 and keeps the state; it is ignored in FECHANDO.
REQ-029 zera_contagem coinciding with garrafa_entregue in ENCHENDO: result count=0; the clear wins.
REQ-030 Counter and stock arithmetic never wrap; no underflow below 0 and no overflow above the limits.

Reset
REQ-031 Reset forces state SEM_CAIXA, estoque_caixas=ESTOQUE_INICIAL, garrafas_na_caixa=0, and all 1-bit outputs 0 except alarme_sem_caixa, which follows the stock.
REQ-032 Reset mid-FECHANDO aborts sealing; fechando_caixa=0 on the next cycle; incrementar_duzia is not issued.
REQ-033 Reset captures the switch level into the edge register, so a switch already high at release does not add a box.

Verification
REQ-034 Reset release with defaults -> cycle 1 POSICIONAR, cycle 2 ENCHENDO, pronto_receber=1, estoque_caixas=4, garrafas_na_caixa=0.
REQ-035 12 garrafa_entregue pulses -> count 12, fechando_caixa high 8 cycles, exactly one incrementar_duzia, then stock 3, count 0.
REQ-036 Bottle pulse during FECHANDO -> count stays 12, garrafa_perdida pulses once, no extra duzia.
REQ-037 ESTOQUE_INICIAL=1, fill one box -> after sealing enter SEM_CAIXA, alarme_sem_caixa=1; one switch edge -> stock 1, then POSICIONAR, stock 0, ENCHENDO.
REQ-038 Switch held high 50 cycles with stock 98 -> stock 99; second edge -> stays 99.
REQ-039 Reset asserted on FECHANDO cycle 3 -> fechando_caixa=0, incrementar_duzia never pulses, stock=ESTOQUE_INICIAL.
